// File: rtl/ext_mem_loader_pkg.sv
// Shared types and constants for the external memory loader: opcodes, FSM states, command payload.
package ext_mem_loader_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned IDATA_W = 32;
    localparam int unsigned OP_W    = 3;

    localparam logic [OP_W-1:0] OP_WR_IMEM = 3'b000;
    localparam logic [OP_W-1:0] OP_WR_DMEM = 3'b001;
    localparam logic [OP_W-1:0] OP_RD_IMEM = 3'b010;
    localparam logic [OP_W-1:0] OP_RD_DMEM = 3'b011;
    localparam logic [OP_W-1:0] OP_RUN     = 3'b100;
    localparam logic [OP_W-1:0] OP_HALT    = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    // Opcodes 0..3 touch a memory; bit 1 selects read, bit 0 selects DMEM.
    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return op[2] == 1'b0;
    endfunction

endpackage

// File: rtl/reg_arstn_en.sv
// Enabled data register with asynchronous active-low reset to a preset value.
module reg_arstn_en #(
    parameter int unsigned        DATA_W     = 64,
    parameter logic [DATA_W-1:0]  PRESET_VAL = '0
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            dout <= PRESET_VAL;
        end else if (en) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ext_mem_loader.sv
// Host-side initiator for the CPU IMEM/DMEM external ports; also owns the CPU enable and run budget.
module ext_mem_loader
    import ext_mem_loader_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [OP_W-1:0]    cmd_op,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               running,
    output logic               cpu_enable,
    output logic [ADDR_W-1:0]  addr_ext,
    output logic               wen_ext,
    output logic               ren_ext,
    output logic [IDATA_W-1:0] wdata_ext,
    input  logic [IDATA_W-1:0] rdata_ext,
    output logic [ADDR_W-1:0]  addr_ext_2,
    output logic               wen_ext_2,
    output logic               ren_ext_2,
    output logic [DATA_W-1:0]  wdata_ext_2,
    input  logic [DATA_W-1:0]  rdata_ext_2
);

    localparam int unsigned WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    cmd_t              cmd;
    state_t            state_q;
    state_t            state_d;
    logic              alive_q;
    logic              is_rd_q;
    logic              is_dmem_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  budget_q;
    logic              cmd_fire;
    logic              mem_fire;
    logic              wen_d;
    logic              ren_d;
    logic              wen2_d;
    logic              ren2_d;
    logic              rsp_valid_d;
    logic              cap_en_c;
    logic [DATA_W-1:0] cap_din_c;

    assign cmd = cmd_t'{op: cmd_op, addr: cmd_addr, wdata: cmd_wdata};

    // alive_q keeps cmd_ready low until the first clock after reset release.
    assign cmd_ready = alive_q && (state_q == ST_IDLE) && (!cpu_enable || !is_mem_op(cmd.op));
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign mem_fire  = cmd_fire && is_mem_op(cmd.op);
    assign running   = cpu_enable;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (mem_fire) state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (!is_rd_q)         state_d = ST_IDLE;
                else if (RD_LAT <= 1) state_d = ST_CAPTURE;
                else                  state_d = ST_WAIT;
            end
            ST_WAIT:    if (wait_q == WAIT_W'(RD_LAT - 2)) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wen_d       = 1'b0;
        ren_d       = 1'b0;
        wen2_d      = 1'b0;
        ren2_d      = 1'b0;
        rsp_valid_d = (state_d == ST_RESP);
        cap_en_c    = (state_q == ST_CAPTURE);
        cap_din_c   = is_dmem_q ? rdata_ext_2 : DATA_W'(rdata_ext);
        if (mem_fire) begin
            wen_d  = (cmd.op == OP_WR_IMEM);
            wen2_d = (cmd.op == OP_WR_DMEM);
            ren_d  = (cmd.op == OP_RD_IMEM);
            ren2_d = (cmd.op == OP_RD_DMEM);
        end
    end

    // Registered ext-port drive; address/data hold their last values between commands.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            alive_q     <= 1'b0;
            is_rd_q     <= 1'b0;
            is_dmem_q   <= 1'b0;
            wen_ext     <= 1'b0;
            ren_ext     <= 1'b0;
            wen_ext_2   <= 1'b0;
            ren_ext_2   <= 1'b0;
            rsp_valid   <= 1'b0;
            addr_ext    <= '0;
            addr_ext_2  <= '0;
            wdata_ext   <= '0;
            wdata_ext_2 <= '0;
        end else begin
            alive_q   <= 1'b1;
            wen_ext   <= wen_d;
            ren_ext   <= ren_d;
            wen_ext_2 <= wen2_d;
            ren_ext_2 <= ren2_d;
            rsp_valid <= rsp_valid_d;
            if (mem_fire) begin
                is_rd_q   <= cmd.op[1];
                is_dmem_q <= cmd.op[0];
                if (cmd.op[0]) addr_ext_2 <= cmd.addr;
                else           addr_ext   <= cmd.addr;
                if (cmd.op == OP_WR_IMEM) wdata_ext   <= cmd.wdata[IDATA_W-1:0];
                if (cmd.op == OP_WR_DMEM) wdata_ext_2 <= cmd.wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wait_q <= '0;
        end else if (state_q == ST_WAIT) begin
            wait_q <= wait_q + WAIT_W'(1);
        end else begin
            wait_q <= '0;
        end
    end

    // Run control: a zero budget runs until HALT; otherwise enable drops after exactly budget cycles.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cpu_enable <= 1'b0;
            budget_q   <= '0;
        end else if (cmd_fire && cmd.op == OP_RUN) begin
            cpu_enable <= 1'b1;
            budget_q   <= cmd.wdata[CNT_W-1:0];
        end else if (cmd_fire && cmd.op == OP_HALT) begin
            cpu_enable <= 1'b0;
            budget_q   <= '0;
        end else if (cpu_enable && budget_q != '0) begin
            budget_q <= budget_q - CNT_W'(1);
            if (budget_q == CNT_W'(1)) cpu_enable <= 1'b0;
        end
    end

    reg_arstn_en #(
        .DATA_W     (DATA_W),
        .PRESET_VAL ('0)
    ) u_rsp_reg (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (cap_en_c),
        .din    (cap_din_c),
        .dout   (rsp_data)
    );

endmodule

// File: tb/tb_ext_mem_loader.sv
// Self-checking bench for ext_mem_loader: vector table, hand-written corner sequences, randomized traffic.
module tb_ext_mem_loader;

    localparam int unsigned RD_LAT = 3;
    localparam int unsigned CNT_W  = 32;
    localparam logic [2:0] WRI = 3'd0, WRD = 3'd1, RDI = 3'd2, RDD = 3'd3, RUN = 3'd4, HALT = 3'd5, NOP = 3'd6;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [63:0] cmd_addr = '0;
    logic [63:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic        running, cpu_enable;
    logic [63:0] addr_ext, addr_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] wdata_ext, rdata_ext;
    logic [63:0] wdata_ext_2, rdata_ext_2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ext_mem_loader #(.RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst_n(arst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .running(running), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
    );

    // Synchronous SRAM stand-ins; read data is valid for one cycle only, RD_LAT cycles after the strobe.
    logic [31:0] imem_m [256];
    logic [63:0] dmem_m [256];
    logic [31:0] ipipe [RD_LAT];
    logic [63:0] dpipe [RD_LAT];
    assign rdata_ext   = ipipe[RD_LAT-1];
    assign rdata_ext_2 = dpipe[RD_LAT-1];

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem_m[i] = '0;
            dmem_m[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (wen_ext)   imem_m[addr_ext[10:3]]   <= wdata_ext;
        if (wen_ext_2) dmem_m[addr_ext_2[10:3]] <= wdata_ext_2;
        ipipe[0] <= ren_ext   ? imem_m[addr_ext[10:3]]   : 32'hBAD0_BAD0;
        dpipe[0] <= ren_ext_2 ? dmem_m[addr_ext_2[10:3]] : 64'hBAD0_BAD0_BAD0_BAD0;
        for (int k = 1; k < RD_LAT; k++) begin
            ipipe[k] <= ipipe[k-1];
            dpipe[k] <= dpipe[k-1];
        end
    end

    // Reference contents: what the host has asked to be stored.
    logic [31:0] ref_i [logic [63:0]];
    logic [63:0] ref_d [logic [63:0]];

    function automatic logic [63:0] ref_read(input logic [2:0] op, input logic [63:0] a);
        if (op == RDI) return ref_i.exists(a) ? {32'h0, ref_i[a]} : 64'h0;
        return ref_d.exists(a) ? ref_d[a] : 64'h0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] d, output bit ok);
        int w;
        w = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
        #1;
        while (!cmd_ready && w < 200) begin
            @(negedge clk); #1;
            w++;
        end
        if (!cmd_ready) begin
            checks++; fails++;
            $display("FAIL cmd_accept_timeout: op %0d never accepted", op);
            cmd_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic do_write(input logic [2:0] op, input logic [63:0] a, input logic [63:0] d);
        bit ok;
        issue(op, a, d, ok);
        if (!ok) return;
        if (op == WRI) begin
            chk("wr_imem_strobe", 64'(wen_ext), 64'd1);
            chk("wr_imem_quiet", 64'({wen_ext_2, ren_ext, ren_ext_2}), 64'd0);
            chk("wr_imem_addr", addr_ext, a);
            chk("wr_imem_data", 64'(wdata_ext), {32'h0, d[31:0]});
            ref_i[a] = d[31:0];
        end else begin
            chk("wr_dmem_strobe", 64'(wen_ext_2), 64'd1);
            chk("wr_dmem_quiet", 64'({wen_ext, ren_ext, ren_ext_2}), 64'd0);
            chk("wr_dmem_addr", addr_ext_2, a);
            chk("wr_dmem_data", wdata_ext_2, d);
            ref_d[a] = d;
        end
        chk("wr_busy", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("wr_strobe_drop", 64'({wen_ext, wen_ext_2}), 64'd0);
        chk("wr_ready_back", 64'(cmd_ready), 64'd1);
    endtask

    task automatic do_read(input logic [2:0] op, input logic [63:0] a, input logic [63:0] exp, input int hold);
        bit ok;
        bit stable;
        int k;
        issue(op, a, 64'h0, ok);
        if (!ok) return;
        if (op == RDI) begin
            chk("rd_imem_strobe", 64'({ren_ext, ren_ext_2, wen_ext, wen_ext_2}), 64'b1000);
            chk("rd_imem_addr", addr_ext, a);
        end else begin
            chk("rd_dmem_strobe", 64'({ren_ext, ren_ext_2, wen_ext, wen_ext_2}), 64'b0100);
            chk("rd_dmem_addr", addr_ext_2, a);
        end
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) chk("rd_strobe_drop", 64'({ren_ext, ren_ext_2}), 64'd0);
        end
        chk("rd_latency", 64'(k), 64'(RD_LAT + 1));
        chk("rd_data", rsp_data, exp);
        chk("rd_busy", 64'(cmd_ready), 64'd0);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== exp || cmd_ready) stable = 1'b0;
        end
        if (hold > 0) chk("rd_hold_stable", 64'(stable), 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rd_rsp_drop", 64'(rsp_valid), 64'd0);
        chk("rd_ready_back", 64'(cmd_ready), 64'd1);
    endtask

    task automatic run_count(input logic [31:0] budget);
        bit ok;
        int n;
        issue(RUN, 64'h0, 64'(budget), ok);
        if (!ok) return;
        chk("run_running_copy", 64'(running), 64'd1);
        n = 0;
        while (cpu_enable && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("run_budget_cycles", 64'(n), 64'(budget));
    endtask

    task automatic pulse_reset();
        #1 arst_n = 1'b0;
        #1;
        chk("rst_pulse_outs", 64'({rsp_valid, cpu_enable, running, cmd_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
        chk("rst_pulse_rsp_data", rsp_data, 64'h0);
        #1 arst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [63:0] addr;
        logic [63:0] data;
        int          hold;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit blocked;
        bit seen;
        int n;

        tbl[0]  = '{WRI,  64'h8,   64'h0000_0000_00A0_0093, 0};
        tbl[1]  = '{WRD,  64'h10,  64'hDEAD_BEEF_CAFE_F00D, 0};
        tbl[2]  = '{RDD,  64'h10,  64'hDEAD_BEEF_CAFE_F00D, 5};
        tbl[3]  = '{RDI,  64'h8,   64'h0000_0000_00A0_0093, 0};
        tbl[4]  = '{WRI,  64'h100, 64'hFFFF_FFFF_1234_5678, 0};
        tbl[5]  = '{RDI,  64'h100, 64'h0000_0000_1234_5678, 2};
        tbl[6]  = '{RDD,  64'h18,  64'h0,                   1};
        tbl[7]  = '{WRD,  64'h10,  64'h0123_4567_89AB_CDEF, 0};
        tbl[8]  = '{RDD,  64'h10,  64'h0123_4567_89AB_CDEF, 0};
        tbl[9]  = '{NOP,  64'h8,   64'h0,                   0};
        tbl[10] = '{HALT, 64'h0,   64'h0,                   0};
        tbl[11] = '{RDI,  64'h8,   64'h0000_0000_00A0_0093, 3};

        // Reset held with a command presented.
        cmd_valid = 1'b1; cmd_op = WRI; cmd_addr = 64'h8; cmd_wdata = 64'h1234;
        repeat (3) @(negedge clk);
        chk("reset_ctrl_outs", 64'({cmd_ready, rsp_valid, cpu_enable, running, wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
        chk("reset_addr", addr_ext | addr_ext_2, 64'h0);
        chk("reset_wdata", 64'(wdata_ext) | wdata_ext_2, 64'h0);
        chk("reset_rsp_data", rsp_data, 64'h0);
        cmd_valid = 1'b0;
        arst_n = 1'b1;
        #1;
        chk("reset_ready_before_clk", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("reset_ready_after", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            case (tbl[i].op)
                WRI, WRD: do_write(tbl[i].op, tbl[i].addr, tbl[i].data);
                RDI, RDD: do_read(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].hold);
                default: begin
                    issue(tbl[i].op, tbl[i].addr, tbl[i].data, ok);
                    chk("ctrl_no_strobe", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2, rsp_valid}), 64'd0);
                    chk("ctrl_idle_enable", 64'(cpu_enable), 64'd0);
                    @(negedge clk);
                    chk("ctrl_ready", 64'(cmd_ready), 64'd1);
                end
            endcase
        end

        // RUN 20 with a memory write stalled behind it.
        issue(RUN, 64'h0, 64'd20, ok);
        cmd_valid = 1'b1; cmd_op = WRI; cmd_addr = 64'h40; cmd_wdata = 64'h0000_0000_0000_0013;
        #1;
        n = 0; blocked = 1'b1;
        while (cpu_enable && n < 200) begin
            if (cmd_ready) blocked = 1'b0;
            n++;
            @(negedge clk); #1;
        end
        chk("run20_cycles", 64'(n), 64'd20);
        chk("run20_mem_stalled", 64'(blocked), 64'd1);
        chk("run20_ready_after", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("run20_wr_strobe", 64'(wen_ext), 64'd1);
        chk("run20_wr_addr", addr_ext, 64'h40);
        ref_i[64'h40] = 32'h13;
        @(negedge clk);
        do_read(RDI, 64'h40, 64'h13, 1);

        // Unbounded RUN stopped by HALT.
        issue(RUN, 64'h0, 64'd0, ok);
        blocked = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (!cpu_enable) blocked = 1'b0;
            @(negedge clk);
        end
        chk("run0_stays_on", 64'(blocked), 64'd1);
        issue(HALT, 64'h0, 64'h0, ok);
        chk("halt_enable", 64'({cpu_enable, running}), 64'd0);

        // RUN while running reloads the budget; budget of one.
        issue(RUN, 64'h0, 64'd10, ok);
        repeat (4) @(negedge clk);
        run_count(32'd5);
        run_count(32'd1);

        // Reset during WAIT of an IMEM read.
        issue(RDI, 64'h8, 64'h0, ok);
        @(negedge clk);
        pulse_reset();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid || ren_ext) seen = 1'b1;
        end
        chk("rst_wait_no_rsp", 64'(seen), 64'd0);
        chk("rst_wait_idle", 64'(cmd_ready), 64'd1);
        do_read(RDI, 64'h8, ref_read(RDI, 64'h8), 0);

        // Reset while a response is pending.
        issue(RDD, 64'h10, 64'h0, ok);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_resp_reached", 64'(rsp_valid), 64'd1);
        pulse_reset();
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("rst_resp_dropped", 64'(seen), 64'd0);
        chk("rst_resp_idle", 64'(cmd_ready), 64'd1);

        // Reset while the CPU runs.
        issue(RUN, 64'h0, 64'd0, ok);
        pulse_reset();
        @(negedge clk);
        chk("rst_run_cleared", 64'(cpu_enable), 64'd0);

        // Randomized traffic against the reference contents.
        for (int it = 0; it < 60; it++) begin
            int unsigned r;
            logic [63:0] a, d;
            r = $urandom_range(0, 9);
            a = 64'(8 * $urandom_range(0, 7));
            d = {$urandom, $urandom};
            case (r)
                0, 1:    do_write(WRI, a, d);
                2:       do_write(WRD, a, d);
                3, 4:    do_read(RDI, a, ref_read(RDI, a), int'($urandom_range(0, 3)));
                5, 6:    do_read(RDD, a, ref_read(RDD, a), int'($urandom_range(0, 3)));
                7: begin
                    issue(NOP, a, d, ok);
                    chk("rand_nop_quiet", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable}), 64'd0);
                end
                8:       run_count(32'($urandom_range(1, 12)));
                default: repeat ($urandom_range(1, 3)) @(negedge clk);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
